// File: rtl/pll_phase_supervisor.sv
// ECP5 EHXPLLL supervisor: lock-qualified system reset plus dynamic phase-step sequencing.
// Optional PLL_RELOCK_RST_EN: pulse PLL RST after a long unlocked stretch in WAIT_LOCK.
`timescale 1ns/1ps
module pll_phase_supervisor #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int SETUP_CYCLES   = 4,
  parameter int STEP_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int RELOCK_TIMEOUT = 65536
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       sys_rst_n,
  output logic       pll_ready,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_count,
  output logic       done,
  output logic       abort,
  output logic       busy,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_rst,
  output logic [7:0] lock_loss_count
);
  localparam int M1   = (LOCK_CYCLES > SETTLE_CYCLES) ? LOCK_CYCLES : SETTLE_CYCLES;
  localparam int M2   = (SETUP_CYCLES > STEP_CYCLES) ? SETUP_CYCLES : STEP_CYCLES;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {WAIT_LOCK, IDLE, SETUP, STEP, SETTLE, FINISH} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    steps, steps_d;
  logic          sync1, lk;
  logic          sys_rst_n_d, pll_ready_d, req_ready_d, done_d, abort_d, busy_d;
  logic [1:0]    sel_d;
  logic          dir_d, step_d;
  logic [7:0]    llc_d;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    steps_d     = steps;
    sys_rst_n_d = sys_rst_n;
    pll_ready_d = pll_ready;
    req_ready_d = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    busy_d      = busy;
    sel_d       = pll_phasesel;
    dir_d       = pll_phasedir;
    step_d      = pll_phasestep;
    llc_d       = lock_loss_count;
    // Lock loss overrides everything, including a handshake on the same edge.
    if (state != WAIT_LOCK && !lk) begin
      state_d     = WAIT_LOCK;
      cnt_d       = '0;
      sys_rst_n_d = 1'b0;
      pll_ready_d = 1'b0;
      step_d      = 1'b1;
      abort_d     = busy;
      busy_d      = 1'b0;
      llc_d       = (lock_loss_count == 8'hFF) ? 8'hFF : lock_loss_count + 8'd1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!lk) cnt_d = '0;
          else if (cnt == CW'(LOCK_CYCLES - 1)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sys_rst_n_d = 1'b1;
            pll_ready_d = 1'b1;
            req_ready_d = 1'b1;
          end else cnt_d = cnt + CW'(1);
        end
        IDLE: begin
          req_ready_d = 1'b1;
          if (req_valid && req_ready) begin
            req_ready_d = 1'b0;
            busy_d      = 1'b1;
            steps_d     = req_count;
            cnt_d       = '0;
            if (req_count == 8'd0) state_d = FINISH;
            else begin
              sel_d   = req_sel;
              dir_d   = req_dir;
              state_d = SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            cnt_d   = '0;
            step_d  = 1'b0;
            state_d = STEP;
          end else cnt_d = cnt + CW'(1);
        end
        STEP: begin
          if (cnt == CW'(STEP_CYCLES - 1)) begin
            cnt_d   = '0;
            step_d  = 1'b1;
            state_d = SETTLE;
          end else cnt_d = cnt + CW'(1);
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            steps_d = steps - 8'd1;
            state_d = (steps == 8'd1) ? FINISH : SETUP;
          end else cnt_d = cnt + CW'(1);
        end
        FINISH: begin
          // Extra cycle so completion lands 24*N+1 cycles after acceptance.
          done_d      = 1'b1;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      steps           <= '0;
      sys_rst_n       <= 1'b0;
      pll_ready       <= 1'b0;
      req_ready       <= 1'b0;
      done            <= 1'b0;
      abort           <= 1'b0;
      busy            <= 1'b0;
      pll_phasesel    <= 2'd0;
      pll_phasedir    <= 1'b0;
      pll_phasestep   <= 1'b1;
      lock_loss_count <= 8'd0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      steps           <= steps_d;
      sys_rst_n       <= sys_rst_n_d;
      pll_ready       <= pll_ready_d;
      req_ready       <= req_ready_d;
      done            <= done_d;
      abort           <= abort_d;
      busy            <= busy_d;
      pll_phasesel    <= sel_d;
      pll_phasedir    <= dir_d;
      pll_phasestep   <= step_d;
      lock_loss_count <= llc_d;
    end
  end

`ifdef PLL_RELOCK_RST_EN
  localparam int RW = $clog2(RELOCK_TIMEOUT + 1);
  logic [RW-1:0] rcnt;
  logic [4:0]    pcnt;

  // Timeout counter pauses while a pulse is active; the pulse itself is never cut short.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      rcnt    <= '0;
      pcnt    <= '0;
      pll_rst <= 1'b0;
    end else begin
      if (lk || state != WAIT_LOCK) rcnt <= '0;
      else if (pcnt == 5'd0) begin
        if (rcnt == RW'(RELOCK_TIMEOUT - 1)) begin
          rcnt    <= '0;
          pcnt    <= 5'd16;
          pll_rst <= 1'b1;
        end else rcnt <= rcnt + RW'(1);
      end
      if (pcnt != 5'd0) begin
        pcnt <= pcnt - 5'd1;
        if (pcnt == 5'd1) pll_rst <= 1'b0;
      end
    end
  end
`else
  // Timeout parameter has no effect in this build; RST stays tied low.
  assign pll_rst = (RELOCK_TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_pll_phase_supervisor.sv
// Bench for pll_phase_supervisor: timeline-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_pll_phase_supervisor;
  localparam int LOCKN = 1024;
  localparam int T_SU  = 4;
  localparam int T_ST  = 4;
  localparam int T_SE  = 16;
  localparam int PER   = T_SU + T_ST + T_SE;
  localparam int RTO   = 100;

  logic       clkin = 1'b0, rst_n = 1'b0, pll_locked = 1'b0;
  logic       req_valid = 1'b0, req_dir = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic [7:0] req_count = 8'd0;
  logic       sys_rst_n, pll_ready, req_ready, done, abort, busy;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir, pll_phasestep, pll_rst;
  logic [7:0] lock_loss_count;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  pll_phase_supervisor #(.LOCK_CYCLES(LOCKN), .SETUP_CYCLES(T_SU), .STEP_CYCLES(T_ST),
                         .SETTLE_CYCLES(T_SE), .RELOCK_TIMEOUT(RTO)) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_locked(pll_locked),
    .sys_rst_n(sys_rst_n), .pll_ready(pll_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_dir(req_dir),
    .req_count(req_count), .done(done), .abort(abort), .busy(busy),
    .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep),
    .pll_rst(pll_rst), .lock_loss_count(lock_loss_count));

  always #20 clkin = ~clkin;

  // Reference model: lock history, request timeline (t0, N) and event times.
  int  cyc, t0, nreq, run, ul, pleft, ppre, el;
  bit  act, rel, p1, p2, lkv;
  logic       e_sys, e_rdy, e_done, e_abort, e_busy, e_dir, e_step, e_prst;
  logic [1:0] e_sel;
  logic [7:0] e_llc;

  function automatic bit step_low(int e, int n);
    return (e >= T_SU) && (((e - T_SU) % PER) < T_ST) && (((e - T_SU) / PER) < n);
  endfunction

  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; act = 0; rel = 0; run = 0; p1 = 0; p2 = 0; ul = 0; pleft = 0; t0 = 0; nreq = 0;
      e_sys = 0; e_rdy = 0; e_done = 0; e_abort = 0; e_busy = 0; e_sel = 0; e_dir = 0;
      e_step = 1; e_llc = 0; e_prst = 0;
    end else begin
      lkv = p2; p2 = p1; p1 = pll_locked;
      cyc++; e_done = 0; e_abort = 0;
`ifdef PLL_RELOCK_RST_EN
      ppre = pleft;
      if (ppre > 0) pleft--;
      if (lkv || rel) ul = 0;
      else if (ppre == 0) begin
        ul++;
        if (ul == RTO) begin pleft = 16; ul = 0; end
      end
      e_prst = (pleft > 0);
`else
      e_prst = 1'b0;
`endif
      if (!rel) begin
        if (lkv) begin
          run++;
          if (run == LOCKN) begin rel = 1; run = 0; end
        end else run = 0;
      end else if (!lkv) begin
        rel = 0; run = 0;
        if (e_llc != 8'hFF) e_llc = e_llc + 8'd1;
        if (act) begin e_abort = 1; act = 0; end
      end else if (act) begin
        if (cyc - t0 == PER * nreq + 1) begin e_done = 1; act = 0; end
      end else if (req_valid && e_rdy) begin
        act = 1; t0 = cyc; nreq = req_count;
        if (nreq > 0) begin e_sel = req_sel; e_dir = req_dir; end
      end
      el = cyc - t0;
      e_sys = rel; e_rdy = rel && !act; e_busy = act;
      e_step = !(act && nreq > 0 && step_low(el, nreq));
    end
  end

  always @(negedge clkin) begin
    if (chk_on) begin
      total++;
      if ({sys_rst_n, pll_ready, req_ready, done, abort, busy, pll_phasesel, pll_phasedir,
           pll_phasestep, pll_rst, lock_loss_count} !==
          {e_sys, e_sys, e_rdy, e_done, e_abort, e_busy, e_sel, e_dir, e_step, e_prst, e_llc}) begin
        bad++;
        $display("FAIL model t=%0t sys/rdy/reqrdy/done/abort/busy/sel/dir/step/rst/llc got %b%b%b%b%b%b %0d %b%b%b %0d want %b%b%b%b%b%b %0d %b%b%b %0d",
          $time, sys_rst_n, pll_ready, req_ready, done, abort, busy, pll_phasesel, pll_phasedir,
          pll_phasestep, pll_rst, lock_loss_count, e_sys, e_sys, e_rdy, e_done, e_abort, e_busy,
          e_sel, e_dir, e_step, e_prst, e_llc);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic wait_rel(output int n);
    n = 0;
    do begin @(posedge clkin); #1; n++; end while (!sys_rst_n && n < 3000);
  endtask

  task automatic run_req(input logic [1:0] s, input logic d, input logic [7:0] c, input int drop_at,
                         output int n, output bit gd, output bit ga,
                         output int falls, output int first, output int last);
    logic prev;
    @(negedge clkin);
    req_valid = 1'b1; req_sel = s; req_dir = d; req_count = c;
    @(posedge clkin); #1;
    req_valid = 1'b0;
    n = 0; gd = 0; ga = 0; falls = 0; first = -1; last = -1; prev = 1'b1;
    while (!gd && !ga && n < 400) begin
      @(posedge clkin); #1; n++;
      if (pll_phasestep == 1'b0 && prev == 1'b1) begin
        falls++;
        if (first < 0) first = n;
        last = n;
      end
      prev = pll_phasestep; gd = done; ga = abort;
      if (n == drop_at) pll_locked = 1'b0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, falls, first, last, rises;
    bit gd, ga;
    logic prev;
    pll_locked = 1'b1;
    chk_on = 1'b1;
    #55;
    check("reset_phasestep", pll_phasestep, 1);
    check("reset_sys_rst_n", sys_rst_n, 0);
    @(negedge clkin); rst_n = 1'b1;
    wait_rel(n);
    check("first_release_cycles", n, 1026);

    // 1: async reset in the middle of a step pulse
    @(negedge clkin);
    req_valid = 1'b1; req_sel = 2'd3; req_dir = 1'b1; req_count = 8'd2;
    @(posedge clkin); #1; req_valid = 1'b0;
    repeat (6) @(posedge clkin);
    #1;
    check("midstep_phasestep_low", pll_phasestep, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_step", pll_phasestep, 1);
    check("async_rst_busy_sel", {busy, req_ready, sys_rst_n, pll_ready, pll_phasesel}, 0);
    @(negedge clkin); @(negedge clkin); rst_n = 1'b1;
    wait_rel(n);
    check("release_after_reset", n, 1026);
    check("ready_after_release", {pll_ready, req_ready}, 3);

    // 2: three steps, sel=1 lead
    run_req(2'd1, 1'b1, 8'd3, -1, n, gd, ga, falls, first, last);
    check("req3_done_latency", n, 73);
    check("req3_done_seen", gd, 1);
    check("req3_pulses", falls, 3);
    check("req3_first_pulse", first, 4);
    check("req3_last_pulse", last, 52);
    check("req3_sel_dir", {pll_phasesel, pll_phasedir}, 3'b011);

    // 3: zero-step request
    run_req(2'd2, 1'b0, 8'd0, -1, n, gd, ga, falls, first, last);
    check("req0_done_latency", n, 1);
    check("req0_no_pulse", falls, 0);
    check("req0_sel_kept", pll_phasesel, 1);

    // 4: lock drops during the second pulse of a 5-step request
    run_req(2'd0, 1'b0, 8'd5, 29, n, gd, ga, falls, first, last);
    check("loss_abort_seen", ga, 1);
    check("loss_no_done", gd, 0);
    check("loss_abort_delay_le3", (n - 29 <= 3) ? 1 : 0, 1);
    check("loss_pulses_started", falls, 2);
    check("loss_count_1", lock_loss_count, 1);
    check("loss_outputs", {sys_rst_n, pll_phasestep, busy}, 3'b010);
    repeat (3) @(negedge clkin);
    pll_locked = 1'b1;
    wait_rel(n);
    check("relock_cycles", n, 1026);

    // 5: one-cycle glitch at WAIT_LOCK count 1000
    @(negedge clkin); pll_locked = 1'b0;
    repeat (4) @(negedge clkin);
    pll_locked = 1'b1;
    repeat (1002) @(posedge clkin);
    #1;
    check("glitch_pre_sys_rst_n", sys_rst_n, 0);
    @(negedge clkin); pll_locked = 1'b0;
    @(negedge clkin); pll_locked = 1'b1;
    wait_rel(n);
    check("glitch_release_cycles", n, 1026);
    check("loss_count_2", lock_loss_count, 2);

    // 6: lock held low; PLL reset pulses only with the relock feature
    @(negedge clkin); pll_locked = 1'b0;
    rises = 0; prev = pll_rst;
    repeat (300) begin
      @(posedge clkin); #1;
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
    end
    check("loss_count_3", lock_loss_count, 3);
`ifdef PLL_RELOCK_RST_EN
    check("relock_pulse_count", rises, 2);
`else
    check("pll_rst_never_high", rises, 0);
`endif
    @(negedge clkin);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
